mult_by_32_arbiter: RTL and testbench
=====================================

MULT_BY_32_ARBITER -- requirements
Module: mult_by_32_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the multiplier; legal range 1..4.
REQ-002 SHALL have parameter LATENCY, default 2, number of pipeline register stages from grant to response; legal range 1..4.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ bits, per-requester request valid.
REQ-007 SHALL have port req_data, input, NUM_REQ*10 bits, operand of requester i on bits [10*i+9:10*i].
REQ-008 SHALL have port req_ready, output, NUM_REQ bits, one-hot grant/accept strobe.
REQ-009 SHALL have port rsp_valid, output, 1 bit, response valid.
REQ-010 SHALL have port rsp_data, output, 16 bits, product operand*32.
REQ-011 SHALL have port rsp_id, output, 2 bits, index of the requester that owns the response.
REQ-012 SHALL have port rsp_ready, input, 1 bit, consumer accepts the response.
REQ-013 SHALL have port idle, output, 1 bit, high when no pipeline stage holds a valid entry.

Function
REQ-014 SHALL define advance = !rsp_valid || rsp_ready; all pipeline stages shift only when advance is 1.
REQ-015 SHALL, when advance is 1, grant the first requester with req_valid set, searching cyclically from rr_ptr upward.
REQ-016 SHALL drive req_ready combinationally: at most one bit set, only for the granted requester, and all zero when advance is 0 or no req_valid is set.
REQ-017 SHALL treat a transfer as req_valid[i] && req_ready[i]; a requester holds req_data stable while valid and not ready.
REQ-018 SHALL, on a transfer from requester g, set rr_ptr to (g+1) mod NUM_REQ; rr_ptr is otherwise unchanged.
REQ-019 SHALL compute the product as {1'b0, operand[9:0], 5'b00000}; rsp_data[15] is always 0 and the maximum value is 32736 (0x7FE0).
REQ-020 SHALL capture product, requester index and a valid bit into stage 1 on a transfer, and propagate them one stage per advancing edge.
REQ-021 SHALL drive rsp_valid, rsp_data and rsp_id from the last stage; a transfer at edge N yields rsp_valid at edge N+LATENCY-1 when no stall occurs.
REQ-022 SHALL sustain one transfer per cycle when rsp_ready is held 1.
REQ-023 SHALL, while rsp_valid && !rsp_ready, hold every stage, rsp_data and rsp_id stable and grant nothing.
REQ-024 SHALL, on the cycle rsp_ready rises after a stall, complete the held response and accept a new request in that same cycle.
REQ-025 SHALL insert bubbles (stage valid 0) when no request is granted; bubbles never assert rsp_valid.
REQ-026 SHALL, when NUM_REQ is below 4, zero-extend rsp_id and never grant a nonexistent index.
REQ-027 SHALL assert idle when all stage valid bits are 0.

Reset
REQ-028 SHALL, while reset is 1 at a clock edge, clear all stage valids and data, set rr_ptr to 0, and drive rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0 and idle=1.
REQ-029 SHALL, on reset mid-operation, discard in-flight entries without emitting a response; the next grant after reset starts its search from requester 0.

Verification
REQ-030 SHALL cover single request: LATENCY=2, req_valid=0001, req_data[9:0]=5, rsp_ready=1 -> exactly one response with rsp_data=160 and rsp_id=0, two edges after the transfer.
REQ-031 SHALL cover round-robin: all four requesters valid continuously with operands 1,2,3,4 -> grant order 0,1,2,3,0 and responses 32,64,96,128.
REQ-032 SHALL cover back-pressure: rsp_ready=0 for 5 cycles while a response is valid -> rsp_data and rsp_id stable, req_ready=0 throughout, no data lost after release.
REQ-033 SHALL cover the boundary value: operand 1023 -> rsp_data=32736 with bit15=0; operand 0 -> rsp_data=0 and rsp_valid=1.
REQ-034 SHALL cover reset mid-flight: reset asserted with 2 entries in flight -> no rsp_valid afterwards, idle=1, and the next grant goes to the lowest valid requester.
REQ-035 SHALL cover the simultaneous case: rsp_ready rises on the same cycle as a new req_valid -> the held response completes and the new request is accepted in that cycle.

Source files
------------

// File: rtl/mult_by_32_arbiter.sv
// -----------------------------------------------------------------------------
// mult_by_32_arbiter
//
// Shares a single "multiply by 32" datapath between up to four requesters.
// A round-robin arbiter picks one requester per cycle, the product
// {1'b0, operand, 5'b0} is captured into a LATENCY-deep pipeline together
// with the owner's index, and the last stage drives the response port.
//
// Handshake rules (both sides use strict valid/ready semantics):
//   - A beat transfers on a rising edge where valid && ready are both 1.
//   - A source holds valid and data stable while valid && !ready.
//   - Request side: req_ready is a one-hot accept strobe for the granted
//     requester; it may depend combinationally on req_valid and rsp_ready.
//   - Response side: rsp_valid/rsp_data/rsp_id stay stable while
//     rsp_valid && !rsp_ready.
//
// Parameters
//   NUM_REQ  number of requesters, 1..4
//   LATENCY  pipeline register stages from grant to response, 1..4
//
// Ports
//   clk        single clock, rising-edge active
//   reset      synchronous, active-high reset
//   req_valid  [NUM_REQ-1:0]     per-requester request valid
//   req_data   [NUM_REQ*10-1:0]  operand of requester i on [10*i+9:10*i]
//   req_ready  [NUM_REQ-1:0]     one-hot grant/accept strobe
//   rsp_valid  response valid
//   rsp_data   [15:0] operand * 32
//   rsp_id     [1:0]  index of the requester that owns the response
//   rsp_ready  consumer accepts the response
//   idle       high when no pipeline stage holds a valid entry
// -----------------------------------------------------------------------------
module mult_by_32_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*10-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  output logic [15:0]             rsp_data,
  output logic [1:0]              rsp_id,
  input  logic                    rsp_ready,
  output logic                    idle
);

  // Pipeline storage; index 0 is stage 1, index LATENCY-1 is the output stage.
  logic [LATENCY-1:0] stg_valid;
  logic [15:0]        stg_data [LATENCY];
  logic [1:0]         stg_id   [LATENCY];

  // Round-robin pointer: the requester searched first on the next grant.
  logic [1:0] rr_ptr;

  // Arbiter results.
  logic       grant_any;
  logic [1:0] grant_idx;
  logic [9:0] grant_op;

  // The whole pipeline moves as one unit: it may shift whenever the output
  // stage is empty or is being consumed this cycle.
  logic advance;
  assign advance = !stg_valid[LATENCY-1] || rsp_ready;

  // ---------------------------------------------------------------------------
  // Cyclic priority search starting at rr_ptr. The modulo keeps the search
  // inside 0..NUM_REQ-1, so a nonexistent index can never be granted.
  // ---------------------------------------------------------------------------
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_idx = 2'd0;
    grant_op  = 10'd0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = 2'(idx);
        grant_op  = req_data[idx*10 +: 10];
      end
    end
  end

  // Accept strobe: only when the pipeline can take a new entry, and never
  // while reset is held so no transfer can be claimed during reset.
  always_comb begin
    req_ready = '0;
    if (advance && grant_any && !reset) begin
      req_ready = NUM_REQ'(1) << grant_idx;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin pointer: moves to the slot after the winner on every transfer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= 2'd0;
    end else if (advance && grant_any) begin
      if (grant_idx == 2'(NUM_REQ - 1)) begin
        rr_ptr <= 2'd0;
      end else begin
        rr_ptr <= grant_idx + 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline. Stage 1 captures the product of the granted operand, or a
  // bubble (valid 0, data 0) when nothing was granted. Bubbles carry zero data
  // so the output data never shows stale values after a response leaves.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      stg_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        stg_data[i] <= 16'd0;
        stg_id[i]   <= 2'd0;
      end
    end else if (advance) begin
      stg_valid[0] <= grant_any;
      stg_data[0]  <= grant_any ? {1'b0, grant_op, 5'b00000} : 16'd0;
      stg_id[0]    <= grant_any ? grant_idx : 2'd0;
      for (int i = 1; i < LATENCY; i++) begin
        stg_valid[i] <= stg_valid[i-1];
        stg_data[i]  <= stg_data[i-1];
        stg_id[i]    <= stg_id[i-1];
      end
    end
  end

  // Response port comes straight from the last stage.
  assign rsp_valid = stg_valid[LATENCY-1];
  assign rsp_data  = stg_data[LATENCY-1];
  assign rsp_id    = stg_id[LATENCY-1];

  assign idle = ~|stg_valid;

endmodule

// File: tb/tb_mult_by_32_arbiter.sv
module tb_mult_by_32_arbiter;

  localparam int NUM_REQ = 4;
  localparam int LATENCY = 2;

  // ---------------------------------------------------------------- clock/reset
  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*10-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic [15:0]           rsp_data;
  logic [1:0]            rsp_id;
  logic                  rsp_ready;
  logic                  idle;

  always #5 clk = ~clk;

  mult_by_32_arbiter #(.NUM_REQ(NUM_REQ), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .idle      (idle)
  );

  // ---------------------------------------------------------------- reference model
  // In-flight transactions, oldest first; pos = pipeline position 1..LATENCY.
  typedef struct {
    logic [15:0] data;
    logic [1:0]  id;
    int          pos;
  } ent_t;

  ent_t        m_q[$];
  int          m_rr;
  logic [15:0] exp_q[$];     // accepted response data, in order
  int          grant_log[$]; // model-predicted grants
  logic [15:0] rsp_log[$];   // observed accepted response data

  int          n_tests;
  int          n_fail;
  int          last_grant;
  logic        obs_rv;
  logic [15:0] obs_data;
  logic [1:0]  obs_id;
  logic [NUM_REQ-1:0] obs_rr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: check outputs at the negedge against the model, then
  // advance the model across the rising edge.
  task automatic step();
    logic exp_rv;
    logic exp_adv;
    int   g;
    logic [NUM_REQ-1:0] exp_rr;
    @(negedge clk);
    exp_rv  = (m_q.size() > 0) && (m_q[0].pos == LATENCY);
    exp_adv = !exp_rv || rsp_ready;
    g = -1;
    if (exp_adv && !reset) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx;
        idx = (m_rr + k) % NUM_REQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    exp_rr = (g >= 0) ? NUM_REQ'(1 << g) : '0;
    obs_rv   = rsp_valid;
    obs_data = rsp_data;
    obs_id   = rsp_id;
    obs_rr   = req_ready;
    chk("req_ready", 32'(req_ready), 32'(exp_rr));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("idle", 32'(idle), 32'(m_q.size() == 0));
    if (exp_rv) begin
      chk("rsp_data", 32'(rsp_data), 32'(m_q[0].data));
      chk("rsp_id", 32'(rsp_id), 32'(m_q[0].id));
    end
    if (rsp_valid === 1'b1 && rsp_ready && !reset) rsp_log.push_back(rsp_data);
    last_grant = g;
    if (g >= 0) grant_log.push_back(g);
    @(posedge clk);
    if (reset) begin
      m_q.delete();
      m_rr = 0;
    end else if (exp_adv) begin
      if (exp_rv) exp_q.push_back(m_q.pop_front().data);
      foreach (m_q[i]) m_q[i].pos++;
      if (g >= 0) begin
        ent_t e;
        e.data = 16'(int'(req_data[g*10 +: 10]) * 32);
        e.id   = 2'(g);
        e.pos  = 1;
        m_q.push_back(e);
        m_rr = (g + 1) % NUM_REQ;
      end
    end
    #1;
  endtask

  task automatic set_op(input int i, input logic [9:0] v);
    req_data[i*10 +: 10] = v;
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  logic [15:0] held_data;
  logic [1:0]  held_id;
  logic [9:0]  rnd_op;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_rr    = 0;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;

    // Reset with a requester asking: nothing may be accepted.
    step();
    req_valid = 4'b0001;
    step();
    chk("reset_req_ready", 32'(obs_rr), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_idle", 32'(idle), 32'd1);
    reset     = 1'b0;
    req_valid = '0;

    // Single request, operand 5 -> 160 two edges after the transfer.
    set_op(0, 10'd5);
    req_valid = 4'b0001;
    step();
    chk("single_grant", 32'(last_grant), 32'd0);
    req_valid = '0;
    step();
    chk("single_lat_early", 32'(obs_rv), 32'd0);
    step();
    chk("single_rsp_valid", 32'(obs_rv), 32'd1);
    chk("single_rsp_data", 32'(obs_data), 32'd160);
    chk("single_rsp_id", 32'(obs_id), 32'd0);
    step();
    chk("single_once", 32'(obs_rv), 32'd0);

    // Round-robin from a fresh pointer.
    reset = 1'b1;
    step();
    reset = 1'b0;
    grant_log.delete();
    rsp_log.delete();
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 10'(i + 1));
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) step();
    req_valid = '0;
    for (int i = 0; i < 4; i++) step();
    chk("rr_count", 32'(grant_log.size()), 32'd5);
    chk("rr_g0", 32'(grant_log[0]), 32'd0);
    chk("rr_g1", 32'(grant_log[1]), 32'd1);
    chk("rr_g2", 32'(grant_log[2]), 32'd2);
    chk("rr_g3", 32'(grant_log[3]), 32'd3);
    chk("rr_g4", 32'(grant_log[4]), 32'd0);
    chk("rr_r0", 32'(rsp_log[0]), 32'd32);
    chk("rr_r1", 32'(rsp_log[1]), 32'd64);
    chk("rr_r2", 32'(rsp_log[2]), 32'd96);
    chk("rr_r3", 32'(rsp_log[3]), 32'd128);

    // Back-pressure for 5 cycles, then release while requests are pending.
    grant_log.delete();
    rsp_log.delete();
    req_valid = 4'b1111;
    step();
    step();
    rsp_ready = 1'b0;
    step();
    chk("bp_valid", 32'(obs_rv), 32'd1);
    chk("bp_ready0", 32'(obs_rr), 32'd0);
    held_data = obs_data;
    held_id   = obs_id;
    for (int i = 1; i < 5; i++) begin
      step();
      chk("bp_hold_data", 32'(obs_data), 32'(held_data));
      chk("bp_hold_id", 32'(obs_id), 32'(held_id));
      chk("bp_no_grant", 32'(obs_rr), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    chk("release_rsp_valid", 32'(obs_rv), 32'd1);
    chk("release_accept", 32'(obs_rr != '0), 32'd1);
    chk("release_rsp_data", 32'(rsp_log[rsp_log.size()-1]), 32'(held_data));
    req_valid = '0;
    for (int i = 0; i < 4; i++) step();
    chk("bp_no_loss", 32'(rsp_log.size()), 32'(grant_log.size()));

    // Boundary operands.
    rsp_log.delete();
    set_op(1, 10'd1023);
    req_valid = 4'b0010;
    step();
    set_op(2, 10'd0);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    for (int i = 0; i < 3; i++) step();
    chk("max_data", 32'(rsp_log[0]), 32'd32736);
    chk("max_bit15", 32'(rsp_log[0][15]), 32'd0);
    chk("zero_count", 32'(rsp_log.size()), 32'd2);
    chk("zero_data", 32'(rsp_log[1]), 32'd0);

    // Reset with two entries in flight.
    set_op(2, 10'd7);
    set_op(3, 10'd9);
    req_valid = 4'b1100;
    step();
    step();
    chk("flight_two", 32'(m_q.size()), 32'd2);
    reset = 1'b1;
    step();
    reset     = 1'b0;
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_reset_no_rsp", 32'(obs_rv), 32'd0);
    end
    chk("post_reset_idle", 32'(idle), 32'd1);
    set_op(1, 10'd3);
    req_valid = 4'b0110;
    step();
    chk("post_reset_grant", 32'(last_grant), 32'd1);
    req_valid = '0;
    for (int i = 0; i < 3; i++) step();

    // Randomized traffic; a requester keeps valid/data until accepted.
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] || last_grant == i) begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          case ($urandom_range(0, 9))
            0:       rnd_op = 10'd1023;
            1:       rnd_op = 10'd0;
            default: rnd_op = 10'($urandom_range(0, 1023));
          endcase
          set_op(i, rnd_op);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Drain.
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && m_q.size() > 0; i++) step();
    chk("drain_empty", 32'(m_q.size()), 32'd0);
    step();
    chk("drain_idle", 32'(idle), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
